pipe_exe_mem: RTL and testbench

Execute stage of the 5-stage pipelined MIPS core, together with the EX/MEM pipeline register and the write-back result select.
- **Execute stage:** combinationally computes the ALU result (or JAL return address) and the final destination register number from ID/EX register outputs.
- **EX/MEM register:** captures the result and control for the memory stage on each clock edge.
- **Write-back select:** chooses between the ALU result and the loaded memory word for the register-file write port.

---
 rtl/pipe_exe_mem.sv | 125 ++++++++++++
 tb/tb_pipe_exe_mem.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_exe_mem.sv
// rtl/pipe_exe_mem.sv - MIPS execute stage, EX/MEM pipeline register and write-back select
//
// Purpose:
//   Combinational execute stage (ALU or JAL return address, final destination
//   register), the EX/MEM pipeline register feeding the memory stage, and the
//   write-back mux that drives the register-file write port.
//
// Ports:
//   clock                  pipeline clock, EX/MEM register captures on rising edge
//   resetn                 asynchronous active-low reset, clears EX/MEM outputs
//   ealuc[3:0]             ALU operation code
//   ealuimm                B operand select: 1 = eimm, 0 = eb
//   eshift                 A operand select: 1 = shift amount eimm[10:6], 0 = ea
//   ejal                   instruction is JAL
//   ea, eb, eimm, epc4     operands, extended immediate, PC+4 (32 bits each)
//   ern0[4:0]              destination register number from decode
//   ewreg, em2reg, ewmem   register-write, mem-to-reg, mem-write controls
//   ern[4:0]               final destination register (to hazard logic)
//   ealu[31:0]             execute result (to forwarding logic)
//   mwreg, mm2reg, mwmem   registered controls
//   malu, mb               registered execute result and store data
//   mrn[4:0]               registered destination register
//   walu, wmo              write-back ALU result and memory read data
//   wm2reg                 write-back select: 1 = wmo, 0 = walu
//   wdi[31:0]              register-file write data
//
// Configuration:
//   PIPE_EXE_SLT_EN        when defined, ealuc = 4'b1011 performs signed SLT;
//                          otherwise that code returns 0.

module pipe_exe_mem (
    input  logic        clock,
    input  logic        resetn,
    input  logic [3:0]  ealuc,
    input  logic        ealuimm,
    input  logic        eshift,
    input  logic        ejal,
    input  logic [31:0] ea,
    input  logic [31:0] eb,
    input  logic [31:0] eimm,
    input  logic [31:0] epc4,
    input  logic [4:0]  ern0,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic        ewmem,
    output logic [4:0]  ern,
    output logic [31:0] ealu,
    output logic        mwreg,
    output logic        mm2reg,
    output logic        mwmem,
    output logic [31:0] malu,
    output logic [31:0] mb,
    output logic [4:0]  mrn,
    input  logic [31:0] walu,
    input  logic [31:0] wmo,
    input  logic        wm2reg,
    output logic [31:0] wdi
);

    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_r;

    assign alu_a = eshift  ? {27'b0, eimm[10:6]} : ea;
    assign alu_b = ealuimm ? eimm : eb;

    // Only the low three opcode bits select the basic operations; bit 3
    // distinguishes SLL/SLT within x011 and SRL/SRA within x111.
    always_comb begin
        alu_r = 32'b0;
        case (ealuc[2:0])
            3'b000: alu_r = alu_a + alu_b;
            3'b100: alu_r = alu_a - alu_b;
            3'b001: alu_r = alu_a & alu_b;
            3'b101: alu_r = alu_a | alu_b;
            3'b010: alu_r = alu_a ^ alu_b;
            3'b110: alu_r = {alu_b[15:0], 16'b0};
            3'b011: begin
                if (!ealuc[3]) begin
                    alu_r = alu_b << alu_a[4:0];
                end else begin
`ifdef PIPE_EXE_SLT_EN
                    alu_r = {31'b0, ($signed(alu_a) < $signed(alu_b))};
`else
                    alu_r = 32'b0;
`endif
                end
            end
            3'b111: begin
                if (ealuc[3]) begin
                    alu_r = $unsigned($signed(alu_b) >>> alu_a[4:0]);
                end else begin
                    alu_r = alu_b >> alu_a[4:0];
                end
            end
            default: alu_r = 32'b0;
        endcase
    end

    // JAL links PC+8 into r31; the add wraps naturally at 32 bits.
    assign ealu = ejal ? (epc4 + 32'd4) : alu_r;
    assign ern  = ejal ? 5'd31 : ern0;

    // No enable: upstream stalls inject bubbles by zeroing the controls.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mwreg  <= 1'b0;
            mm2reg <= 1'b0;
            mwmem  <= 1'b0;
            malu   <= 32'b0;
            mb     <= 32'b0;
            mrn    <= 5'b0;
        end else begin
            mwreg  <= ewreg;
            mm2reg <= em2reg;
            mwmem  <= ewmem;
            malu   <= ealu;
            mb     <= eb;
            mrn    <= ern;
        end
    end

    assign wdi = wm2reg ? wmo : walu;

endmodule

// File: tb/tb_pipe_exe_mem.sv
// tb/tb_pipe_exe_mem.sv - self-checking bench for pipe_exe_mem

module tb_pipe_exe_mem;

    logic        clock;
    logic        resetn;
    logic [3:0]  ealuc;
    logic        ealuimm;
    logic        eshift;
    logic        ejal;
    logic [31:0] ea;
    logic [31:0] eb;
    logic [31:0] eimm;
    logic [31:0] epc4;
    logic [4:0]  ern0;
    logic        ewreg;
    logic        em2reg;
    logic        ewmem;
    logic [4:0]  ern;
    logic [31:0] ealu;
    logic        mwreg;
    logic        mm2reg;
    logic        mwmem;
    logic [31:0] malu;
    logic [31:0] mb;
    logic [4:0]  mrn;
    logic [31:0] walu;
    logic [31:0] wmo;
    logic        wm2reg;
    logic [31:0] wdi;

    pipe_exe_mem dut (
        .clock   (clock),
        .resetn  (resetn),
        .ealuc   (ealuc),
        .ealuimm (ealuimm),
        .eshift  (eshift),
        .ejal    (ejal),
        .ea      (ea),
        .eb      (eb),
        .eimm    (eimm),
        .epc4    (epc4),
        .ern0    (ern0),
        .ewreg   (ewreg),
        .em2reg  (em2reg),
        .ewmem   (ewmem),
        .ern     (ern),
        .ealu    (ealu),
        .mwreg   (mwreg),
        .mm2reg  (mm2reg),
        .mwmem   (mwmem),
        .malu    (malu),
        .mb      (mb),
        .mrn     (mrn),
        .walu    (walu),
        .wmo     (wmo),
        .wm2reg  (wm2reg),
        .wdi     (wdi)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic        wreg;
        logic        m2reg;
        logic        wmem;
        logic [31:0] alu;
        logic [31:0] b;
        logic [4:0]  rn;
    } exmem_t;

    exmem_t sb_q[$];
    int vectors = 0;
    int errors  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference ALU written out per full 4-bit opcode.
    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  s;
        s = a[4:0];
        r = 32'b0;
        case (c)
            4'b0000, 4'b1000: r = a + b;
            4'b0100, 4'b1100: r = a - b;
            4'b0001, 4'b1001: r = a & b;
            4'b0101, 4'b1101: r = a | b;
            4'b0010, 4'b1010: r = a ^ b;
            4'b0110, 4'b1110: r = b << 16;
            4'b0011:          r = b << s;
            4'b0111:          r = b >> s;
            4'b1111: begin
                r = b >> s;
                if (b[31]) r = r | ~(32'hFFFF_FFFF >> s);
            end
`ifdef PIPE_EXE_SLT_EN
            4'b1011: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, (a < b)};
`endif
            default: r = 32'b0;
        endcase
        return r;
    endfunction

    function automatic exmem_t model_exmem();
        exmem_t e;
        logic [31:0] a;
        logic [31:0] b;
        a = eshift ? {27'b0, eimm[10:6]} : ea;
        b = ealuimm ? eimm : eb;
        e.wreg  = ewreg;
        e.m2reg = em2reg;
        e.wmem  = ewmem;
        e.alu   = ejal ? epc4 + 32'd4 : ref_alu(ealuc, a, b);
        e.b     = eb;
        e.rn    = ejal ? 5'd31 : ern0;
        return e;
    endfunction

    task automatic check_regs(input string tag, input exmem_t e);
        check({tag, ".mwreg"},  {63'b0, mwreg},  {63'b0, e.wreg});
        check({tag, ".mm2reg"}, {63'b0, mm2reg}, {63'b0, e.m2reg});
        check({tag, ".mwmem"},  {63'b0, mwmem},  {63'b0, e.wmem});
        check({tag, ".malu"},   {32'b0, malu},   {32'b0, e.alu});
        check({tag, ".mb"},     {32'b0, mb},     {32'b0, e.b});
        check({tag, ".mrn"},    {59'b0, mrn},    {59'b0, e.rn});
    endtask

    // Push the expectation for the current inputs, clock once, pop and compare.
    task automatic clock_and_score(input string tag);
        exmem_t e;
        sb_q.push_back(model_exmem());
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, ".queue"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check_regs(tag, e);
        end
    endtask

    initial begin
        exmem_t zero_e;
        zero_e = '0;
        resetn = 1'b0; ealuc = 4'b0; ealuimm = 1'b0; eshift = 1'b0; ejal = 1'b0;
        ea = '0; eb = '0; eimm = '0; epc4 = '0; ern0 = '0;
        ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0;
        walu = '0; wmo = '0; wm2reg = 1'b0;
        ewreg = 1'b1; eb = 32'h5555_5555;
        #2;
        check_regs("reset_state", zero_e);
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;

        // ADD and OR
        ea = 32'h5; eb = 32'h3; ealuc = 4'b0000; ealuimm = 1'b0; ewreg = 1'b0;
        #1 check("add", {32'b0, ealu}, {32'b0, 32'h8});
        ealuimm = 1'b1; eimm = 32'hFFFF_FFFF; ealuc = 4'b0101;
        #1 check("or_imm", {32'b0, ealu}, {32'b0, 32'hFFFF_FFFF});

        // Shifts: shift amount from eimm[10:6] = 4
        ealuimm = 1'b0; eshift = 1'b1; eimm = 32'h0000_0100; eb = 32'h8000_0000;
        ealuc = 4'b1111;
        #1 check("sra", {32'b0, ealu}, {32'b0, 32'hF800_0000});
        ealuc = 4'b0111;
        #1 check("srl", {32'b0, ealu}, {32'b0, 32'h0800_0000});
        ealuc = 4'b0011;
        #1 check("sll", {32'b0, ealu}, {32'b0, 32'h0000_0000});
        eshift = 1'b0;

        // JAL
        ejal = 1'b1; epc4 = 32'h10; ern0 = 5'd5;
        #1 check("jal_alu", {32'b0, ealu}, {32'b0, 32'h14});
        check("jal_rn", {59'b0, ern}, {59'b0, 5'd31});
        epc4 = 32'hFFFF_FFFC;
        #1 check("jal_wrap", {32'b0, ealu}, {32'b0, 32'h0});
        ejal = 1'b0;
        #1 check("nojal_rn", {59'b0, ern}, {59'b0, 5'd5});

        // LUI and SUB
        ealuimm = 1'b1; eimm = 32'h0000_ABCD; ealuc = 4'b0110;
        #1 check("lui", {32'b0, ealu}, {32'b0, 32'hABCD_0000});
        ealuimm = 1'b0; ea = 32'h0; eb = 32'h1; ealuc = 4'b0100;
        #1 check("sub_wrap", {32'b0, ealu}, {32'b0, 32'hFFFF_FFFF});

        // SLT boundary: -1 < 1 only when the feature is built in
        ea = 32'hFFFF_FFFF; eb = 32'h1; ealuc = 4'b1011;
`ifdef PIPE_EXE_SLT_EN
        #1 check("slt", {32'b0, ealu}, {32'b0, 32'h1});
`else
        #1 check("slt_off", {32'b0, ealu}, {32'b0, 32'h0});
`endif

        // Register capture
        @(negedge clock);
        ewreg = 1'b1; em2reg = 1'b1; ewmem = 1'b0; eb = 32'hDEAD_BEEF;
        ea = 32'h1000; eimm = 32'h234; ealuimm = 1'b1; ealuc = 4'b0000; ern0 = 5'd7;
        #1 check("reg_ealu", {32'b0, ealu}, {32'b0, 32'h1234});
        clock_and_score("capture");
        check("capture_malu_const", {32'b0, malu}, {32'b0, 32'h1234});
        check("capture_mb_const", {32'b0, mb}, {32'b0, 32'hDEAD_BEEF});

        // Async reset between edges clears immediately and holds across an edge
        @(negedge clock);
        resetn = 1'b0;
        #1 check_regs("async_reset", zero_e);
        @(posedge clock);
        #1 check_regs("reset_hold", zero_e);
        @(negedge clock);
        resetn = 1'b1;
        ewmem = 1'b1;
        clock_and_score("resume");

        // Write-back select
        walu = 32'hAAAA_0000; wmo = 32'h0000_BBBB; wm2reg = 1'b0;
        #1 check("wdi_alu", {32'b0, wdi}, {32'b0, 32'hAAAA_0000});
        wm2reg = 1'b1;
        #1 check("wdi_mem", {32'b0, wdi}, {32'b0, 32'h0000_BBBB});

        // Random traffic through the scoreboard
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            ealuc = 4'($urandom_range(0, 15));
            ealuimm = 1'($urandom); eshift = 1'($urandom); ejal = 1'($urandom_range(0, 3) == 0);
            ea = $urandom; eb = $urandom; eimm = $urandom; epc4 = $urandom;
            ern0 = 5'($urandom); ewreg = 1'($urandom); em2reg = 1'($urandom); ewmem = 1'($urandom);
            #1;
            begin
                exmem_t e;
                e = model_exmem();
                check($sformatf("rand%0d.ealu", i), {32'b0, ealu}, {32'b0, e.alu});
                check($sformatf("rand%0d.ern", i), {59'b0, ern}, {59'b0, e.rn});
            end
            clock_and_score($sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
